trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 32, trace word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of FIFO entries; power of two, minimum 2.
REQ-003 SHALL have parameter CHANGE_ONLY, default 1; when 1, a strobe captures only a changed word.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port trace_in, input, WIDTH, the trace word in the clk domain.
REQ-007 SHALL have port trace_stb, input, 1, capture request for trace_in in this cycle.
REQ-008 SHALL have port out_data, output, WIDTH, the head-of-FIFO word.
REQ-009 SHALL have port out_valid, output, 1, high when out_data holds a word.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts out_data when out_valid is also high.
REQ-011 SHALL have port level, output, log2(DEPTH)+1, number of stored words.
REQ-012 SHALL have port overflow_cnt, output, 8, count of dropped captures, saturating.

Function
REQ-013 A candidate SHALL be a cycle with trace_stb=1 and, when CHANGE_ONLY=1, either trace_in != last_word or first_pending=1.
REQ-014 last_word SHALL load trace_in on every candidate, whether the word is stored or dropped; first_pending SHALL clear on the first candidate.
REQ-015 A candidate SHALL be written to the FIFO when level < DEPTH, measured before any pop in the same cycle.
REQ-016 A candidate arriving with level == DEPTH SHALL be dropped, and overflow_cnt SHALL increment, saturating at 255.
REQ-017 A pop SHALL occur when out_valid=1 and out_ready=1 are sampled together.
REQ-018 On a simultaneous push and pop with level < DEPTH, level SHALL remain unchanged.
REQ-019 On a push alone, level SHALL rise by 1; on a pop alone, level SHALL fall by 1.
REQ-020 The FIFO SHALL be first-word-fall-through.
REQ-021 A word pushed into an empty FIFO SHALL appear on out_data with out_valid=1 in the next cycle (latency 1).
REQ-022 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 out_valid SHALL equal (level != 0).
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH without any special case.
REQ-025 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-026 When CHANGE_ONLY=0, every trace_stb cycle SHALL be a candidate.

Reset
REQ-027 While reset=1, the module SHALL set level=0, out_valid=0, overflow_cnt=0, both pointers=0, last_word=0 and first_pending=1.
REQ-028 While reset=1, out_data SHALL hold all zeros.
REQ-029 Reset asserted mid-operation SHALL discard all stored words in the same edge; pushes and pops in that cycle SHALL be ignored.
REQ-030 FIFO storage contents SHALL NOT require reset.

Structure
REQ-031 TRACE_WIDTH (32) and the trace FIFO depth default SHALL live in a shared trace definitions include, used by this block and the UART tracer.
REQ-032 Storage and pointers SHALL be a sub-module trace_fifo: a synchronous FWFT FIFO with push, pop, din, dout, empty, full and level.
REQ-033 The change filter, last_word, first_pending and overflow counter SHALL reside in trace_capture.
REQ-034 The block SHALL instantiate no vendor primitives.
REQ-035 out_data/out_valid/out_ready SHALL be able to feed the word-oriented UART tracer directly.

Verification
REQ-036 Reset, then trace_stb=1 with trace_in=0x00000000 once -> next cycle out_valid=1, out_data=0x00000000, level=1.
REQ-037 CHANGE_ONLY=1, out_ready=0, strobes with 0x11, 0x11, 0x22, 0x22, 0x11 -> level=3; draining with out_ready=1 yields 0x11, 0x22, 0x11.
REQ-038 DEPTH=16, out_ready=0, 20 distinct strobed words -> level=16, overflow_cnt=4; draining yields the first 16 words in order.
REQ-039 FIFO full and trace_stb plus out_ready high in the same cycle -> pop occurs, new word dropped, level=15, overflow_cnt increments by 1.
REQ-040 300 drops while full -> overflow_cnt=255 and holds there.
REQ-041 level=5 and reset pulsed for 1 cycle -> next cycle level=0, out_valid=0, overflow_cnt=0; the next strobe of the old last value is captured.

Source files
------------

// File: rtl/trace_capture_pkg.sv
// Shared trace definitions used by the capture block and the UART tracer.
// Holds the default trace word width and FIFO depth.
package trace_capture_pkg;

  localparam int TRACE_WIDTH      = 32;
  localparam int TRACE_FIFO_DEPTH = 16;

  // A level counter must represent 0..DEPTH inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Word stream from the capture FIFO head to a consumer such as the UART tracer.
// The master drives data and valid; the slave returns ready.
interface trace_capture_if
  import trace_capture_pkg::*;
#(
  parameter int WIDTH = TRACE_WIDTH
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/trace_capture_fifo.sv
// Synchronous first-word-fall-through FIFO with power-of-two depth.
// Storage is not reset; resetting the pointers and level discards the contents.
module trace_fifo
  import trace_capture_pkg::*;
#(
  parameter  int WIDTH = TRACE_WIDTH,
  parameter  int DEPTH = TRACE_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_level == '0);
  assign full   = (r_level == (AW+1)'(DEPTH));
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign level  = r_level;
  assign dout   = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/trace_capture.sv
// Trace capture: filters strobed trace words (optionally change-only) into a
// FWFT FIFO and counts captures dropped while the FIFO is full.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter  int WIDTH       = TRACE_WIDTH,
  parameter  int DEPTH       = TRACE_FIFO_DEPTH,
  parameter  int CHANGE_ONLY = 1,
  localparam int LW          = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] trace_in,
  input  logic             trace_stb,
  trace_capture_if.master  tif,
  output logic [LW-1:0]    level,
  output logic [7:0]       overflow_cnt
);

  logic [WIDTH-1:0] r_last_word;
  logic             r_first_pending;
  logic [7:0]       r_ovf_cnt;
  logic             w_cand;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [WIDTH-1:0] w_dout;
  logic [LW-1:0]    w_level;

  // The first candidate after reset is always taken, even if it equals the
  // reset value of last_word.
  assign w_cand = trace_stb & ((CHANGE_ONLY == 0) | r_first_pending |
                               (trace_in != r_last_word));
  assign w_push = w_cand & ~w_full & ~reset;
  assign w_pop  = tif.out_ready & ~w_empty & ~reset;

  trace_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (trace_in),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .level (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_word     <= '0;
      r_first_pending <= 1'b1;
      r_ovf_cnt       <= '0;
    end else if (w_cand) begin
      r_last_word     <= trace_in;
      r_first_pending <= 1'b0;
      if (w_full && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign tif.out_valid = ~w_empty;
  assign tif.out_data  = reset ? '0 : w_dout;
  assign level         = w_level;
  assign overflow_cnt  = r_ovf_cnt;

endmodule

// File: tb/tb_trace_capture.sv
// Randomized and directed bench for trace_capture against a queue-based model.
module tb_trace_capture;

  localparam int W     = 32;
  localparam int DEPTH = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] trace_in;
  logic         trace_stb;
  logic [4:0]   level;
  logic [7:0]   overflow_cnt;

  trace_capture_if #(.WIDTH(W)) tif();

  trace_capture #(.WIDTH(W), .DEPTH(DEPTH), .CHANGE_ONLY(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .trace_in     (trace_in),
    .trace_stb    (trace_stb),
    .tif          (tif.master),
    .level        (level),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: stored words, last captured word, first flag, drop count.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;
  bit           m_fp;
  int           m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(mq.size()));
    chk("valid", 32'(tif.out_valid), 32'(mq.size() != 0));
    chk("data",  tif.out_data, (mq.size() != 0) ? mq[0] : 32'h0);
    chk("ovf",   32'(overflow_cnt), 32'(m_ovf));
  endtask

  // Called at a falling edge: drive inputs, advance the model, check next negedge.
  task automatic cyc(input bit rst, input bit stb, input logic [W-1:0] din, input bit rdy);
    bit full, pop, cand;
    reset         = rst;
    trace_stb     = stb;
    trace_in      = din;
    tif.out_ready = rdy;
    if (rst) begin
      mq.delete();
      m_last = '0;
      m_fp   = 1'b1;
      m_ovf  = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = rdy && (mq.size() != 0);
      cand = stb && (m_fp || din != m_last);
      if (cand) begin
        m_last = din;
        m_fp   = 1'b0;
      end
      if (pop) void'(mq.pop_front());
      if (cand) begin
        if (!full) mq.push_back(din);
        else if (m_ovf < 255) m_ovf++;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  logic [W-1:0] seq37 [5] = '{32'h11, 32'h11, 32'h22, 32'h22, 32'h11};
  logic [W-1:0] exp37 [3] = '{32'h11, 32'h22, 32'h11};

  initial begin
    reset = 1'b1; trace_stb = 1'b0; trace_in = '0; tif.out_ready = 1'b0;
    m_last = '0; m_fp = 1'b1; m_ovf = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h55, 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_data",  tif.out_data, 0);

    // Single zero word right after reset is captured with latency 1.
    cyc(0, 1, 32'h0, 0);
    chk("r36_valid", 32'(tif.out_valid), 1);
    chk("r36_level", 32'(level), 1);
    cyc(0, 0, 0, 1);

    // Change-only filtering.
    for (int i = 0; i < 5; i++) cyc(0, 1, seq37[i], 0);
    chk("r37_level", 32'(level), 3);
    for (int i = 0; i < 3; i++) begin
      chk("r37_drain", tif.out_data, exp37[i]);
      cyc(0, 0, 0, 1);
    end
    chk("r37_empty", 32'(tif.out_valid), 0);

    // Overflow with 20 distinct words, then full + push + pop.
    for (int i = 0; i < 20; i++) cyc(0, 1, 32'h1000 + 32'(i), 0);
    chk("r38_level", 32'(level), 16);
    chk("r38_ovf",   32'(overflow_cnt), 4);
    chk("r38_head",  tif.out_data, 32'h1000);
    cyc(0, 1, 32'hBEEF, 1);
    chk("r39_level", 32'(level), 15);
    chk("r39_ovf",   32'(overflow_cnt), 5);
    for (int i = 1; i < 16; i++) begin
      chk("r38_drain", tif.out_data, 32'h1000 + 32'(i));
      cyc(0, 0, 0, 1);
    end
    cyc(0, 0, 0, 1);

    // Saturating drop counter.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 316; i++) cyc(0, 1, 32'h2000 + 32'(i), 0);
    chk("r40_sat", 32'(overflow_cnt), 255);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h3000 + 32'(i), 0);
    chk("r40_hold", 32'(overflow_cnt), 255);

    // Mid-operation reset, then the old last value is captured again.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h40 + 32'(i), 0);
    chk("r41_pre", 32'(level), 5);
    cyc(1, 1, 32'h77, 1);
    chk("r41_level", 32'(level), 0);
    chk("r41_valid", 32'(tif.out_valid), 0);
    chk("r41_ovf",   32'(overflow_cnt), 0);
    cyc(0, 1, 32'h44, 0);
    chk("r41_recap", tif.out_data, 32'h44);

    // Random traffic with varying consumer pressure and occasional resets.
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        bit rs = ($urandom_range(0, 299) == 0);
        bit st = ($urandom_range(0, 99) < 60);
        logic [W-1:0] d = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 3));
        bit rd = ($urandom_range(0, 99) < rdy_pct);
        cyc(rs, st, d, rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
